// File: rtl/pc_pkg.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | pc_pkg : shared constants and next-PC select encoding for pc_gen       |
// | Rev 1.0                                                               |
// +-----------------------------------------------------------------------+
package pc_pkg;

    localparam logic [31:0] c_RESET_VEC = 32'h0000_3000;
    localparam logic [31:0] c_EXC_VEC   = 32'h0000_4180;
    localparam logic [31:0] c_STEP      = 32'd4;

    // Also consumed by the hazard unit for debug visibility.
    typedef enum logic [2:0] {
        NPC_RESET = 3'd0,
        NPC_EXC   = 3'd1,
        NPC_ERET  = 3'd2,
        NPC_REDIR = 3'd3,
        NPC_PEND  = 3'd4,
        NPC_SEQ   = 3'd5,
        NPC_HOLD  = 3'd6
    } npc_sel_e;

endpackage
`default_nettype wire

// File: rtl/pc_redirect_buf.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | pc_redirect_buf : one-entry holder for a redirect arriving in a stall  |
// | Rev 1.0                                                               |
// +-----------------------------------------------------------------------+
module pc_redirect_buf #(
    parameter int WIDTH = 32
) (
    input  logic             Clk,
    input  logic             Reset,
    input  logic             i_capture,
    input  logic             i_clear,
    input  logic [WIDTH-1:0] i_target,
    output logic             o_valid,
    output logic [WIDTH-1:0] o_target
);

    logic             r_valid;
    logic [WIDTH-1:0] r_target;

    // A later capture in the same stall simply overwrites the held target.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            r_valid  <= 1'b0;
            r_target <= '0;
        end else if (i_capture) begin
            r_valid  <= 1'b1;
            r_target <= i_target;
        end else if (i_clear) begin
            r_valid  <= 1'b0;
        end
    end

    assign o_valid  = r_valid;
    assign o_target = r_target;

endmodule
`default_nettype wire

// File: rtl/pc_gen.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | pc_gen : fetch program counter with stall-safe redirect buffering      |
// | Optional fetch address check: define PC_ADDR_CHECK_EN                  |
// | Rev 1.0                                                               |
// +-----------------------------------------------------------------------+
module pc_gen
    import pc_pkg::*;
#(
    parameter int               WIDTH      = 32,
    parameter logic [WIDTH-1:0] RESET_VEC  = WIDTH'(c_RESET_VEC),
    parameter logic [WIDTH-1:0] EXC_VEC    = WIDTH'(c_EXC_VEC),
    parameter logic [WIDTH-1:0] STEP       = WIDTH'(c_STEP),
    parameter logic [WIDTH-1:0] IMEM_BASE  = WIDTH'(32'h0000_3000),
    parameter int               IMEM_WORDS = 4096
) (
    input  logic             Clk,
    input  logic             Reset,
    input  logic             En,
    input  logic             Redirect,
    input  logic [WIDTH-1:0] RedirectTarget,
    input  logic             Exc,
    input  logic             Eret,
    input  logic [WIDTH-1:0] EPC,
    output logic [WIDTH-1:0] PC,
    output logic             PendValid,
    output logic             AdEL
);

    localparam logic [WIDTH:0] c_imem_end = {1'b0, IMEM_BASE} + (WIDTH+1)'(4 * IMEM_WORDS);

    npc_sel_e         w_sel;
    logic [WIDTH-1:0] w_npc;
    logic [WIDTH-1:0] r_pc;
    logic             w_pend_valid;
    logic [WIDTH-1:0] w_pend_target;
    logic             w_capture;
    logic             w_clear;

    // Exc/Eret override a stall; a plain redirect during a stall is parked.
    assign w_capture = Redirect && !En && !Exc && !Eret;
    assign w_clear   = Exc || Eret || En;

    pc_redirect_buf #(
        .WIDTH (WIDTH)
    ) u_redirect_buf (
        .Clk       (Clk),
        .Reset     (Reset),
        .i_capture (w_capture),
        .i_clear   (w_clear),
        .i_target  (RedirectTarget),
        .o_valid   (w_pend_valid),
        .o_target  (w_pend_target)
    );

    always_comb begin
        w_sel = NPC_HOLD;
        if (Reset)                   w_sel = NPC_RESET;
        else if (Exc)                w_sel = NPC_EXC;
        else if (Eret)               w_sel = NPC_ERET;
        else if (En && Redirect)     w_sel = NPC_REDIR;
        else if (En && w_pend_valid) w_sel = NPC_PEND;
        else if (En)                 w_sel = NPC_SEQ;
    end

    always_comb begin
        w_npc = r_pc;
        case (w_sel)
            NPC_RESET: w_npc = RESET_VEC;
            NPC_EXC:   w_npc = EXC_VEC;
            NPC_ERET:  w_npc = EPC;
            NPC_REDIR: w_npc = RedirectTarget;
            NPC_PEND:  w_npc = w_pend_target;
            NPC_SEQ:   w_npc = r_pc + STEP;
            default:   w_npc = r_pc;
        endcase
    end

    always_ff @(posedge Clk) begin
        if (Reset) r_pc <= RESET_VEC;
        else       r_pc <= w_npc;
    end

    assign PC        = r_pc;
    assign PendValid = w_pend_valid;

`ifdef PC_ADDR_CHECK_EN
    logic r_adel;
    logic w_adel_next;

    // Evaluated on the next PC so the flag lands on the same edge as the PC it describes.
    assign w_adel_next = (w_npc[1:0] != 2'b00)
                      || ({1'b0, w_npc} <  {1'b0, IMEM_BASE})
                      || ({1'b0, w_npc} >= c_imem_end);

    always_ff @(posedge Clk) begin
        if (Reset) r_adel <= 1'b0;
        else       r_adel <= w_adel_next;
    end

    assign AdEL = r_adel;
`else
    logic w_unused_cfg;
    assign w_unused_cfg = ^{IMEM_BASE, c_imem_end};
    assign AdEL         = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_pc_gen.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | tb_pc_gen : directed and randomized checks of pc_gen against a model   |
// | Honours PC_ADDR_CHECK_EN for AdEL expectations. Rev 1.0               |
// +-----------------------------------------------------------------------+
module tb_pc_gen;

    logic        Clk = 1'b0;
    logic        Reset = 1'b1;
    logic        En = 1'b0;
    logic        Redirect = 1'b0;
    logic [31:0] RedirectTarget = '0;
    logic        Exc = 1'b0;
    logic        Eret = 1'b0;
    logic [31:0] EPC = '0;
    logic [31:0] PC;
    logic        PendValid;
    logic        AdEL;

    int n_cmp = 0;
    int n_err = 0;
    bit chk_on = 1'b0;

    logic [31:0] m_pc;
    bit          m_pv;
    logic [31:0] m_pt;

    always #5 Clk = ~Clk;

    pc_gen u_dut (
        .Clk            (Clk),
        .Reset          (Reset),
        .En             (En),
        .Redirect       (Redirect),
        .RedirectTarget (RedirectTarget),
        .Exc            (Exc),
        .Eret           (Eret),
        .EPC            (EPC),
        .PC             (PC),
        .PendValid      (PendValid),
        .AdEL           (AdEL)
    );

    function automatic logic adel_exp(input logic [31:0] pc);
`ifdef PC_ADDR_CHECK_EN
        return (pc[1:0] != 2'b00) || (pc < 32'h0000_3000) || (pc >= 32'h0000_7000);
`else
        return 1'b0;
`endif
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    // Architectural next-state rule: priority list applied once per rising edge.
    task automatic model_edge(input bit rst, input bit en, input bit rd, input logic [31:0] tg,
                              input bit ex, input bit er, input logic [31:0] ep);
        if (rst) begin
            m_pc = 32'h0000_3000; m_pv = 1'b0; m_pt = '0;
        end else if (ex) begin
            m_pc = 32'h0000_4180; m_pv = 1'b0;
        end else if (er) begin
            m_pc = ep; m_pv = 1'b0;
        end else if (en) begin
            if (rd)        m_pc = tg;
            else if (m_pv) m_pc = m_pt;
            else           m_pc = m_pc + 32'd4;
            m_pv = 1'b0;
        end else if (rd) begin
            m_pv = 1'b1; m_pt = tg;
        end
    endtask

    task automatic cyc(input bit rst, input bit en, input bit rd, input logic [31:0] tg,
                       input bit ex, input bit er, input logic [31:0] ep);
        @(negedge Clk);
        Reset = rst; En = en; Redirect = rd; RedirectTarget = tg;
        Exc = ex; Eret = er; EPC = ep;
        @(posedge Clk);
        model_edge(rst, en, rd, tg, ex, er, ep);
        if (rst) chk_on = 1'b1;
        #1;
    endtask

    task automatic adv();
        cyc(1'b0, 1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
    endtask

    always @(negedge Clk) begin
        if (chk_on) begin
            chk("pc",   PC, m_pc);
            chk("pend", {31'b0, PendValid}, {31'b0, m_pv});
            chk("adel", {31'b0, AdEL}, {31'b0, adel_exp(m_pc)});
        end
    end

    initial begin
        cyc(1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
        cyc(1'b1, 1'b1, 1'b1, 32'h5555_0000, 1'b1, 1'b1, 32'h0);
        chk("rst_pc", PC, 32'h0000_3000);
        chk("rst_pend", {31'b0, PendValid}, 32'h0);
        chk("rst_adel", {31'b0, AdEL}, 32'h0);

        adv(); chk("seq1", PC, 32'h0000_3004);
        adv(); chk("seq2", PC, 32'h0000_3008);
        adv(); chk("seq3", PC, 32'h0000_300C);
        adv(); chk("seq4", PC, 32'h0000_3010);
        cyc(1'b0, 1'b1, 1'b1, 32'h0000_3400, 1'b0, 1'b0, 32'h0);
        chk("redir", PC, 32'h0000_3400);

        cyc(1'b0, 1'b0, 1'b1, 32'h0000_3500, 1'b0, 1'b0, 32'h0);
        chk("stall1_pc", PC, 32'h0000_3400);
        chk("stall1_pend", {31'b0, PendValid}, 32'h1);
        cyc(1'b0, 1'b0, 1'b1, 32'h0000_3600, 1'b0, 1'b0, 32'h0);
        cyc(1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
        chk("stall3_pc", PC, 32'h0000_3400);
        adv();
        chk("release_pc", PC, 32'h0000_3600);
        chk("release_pend", {31'b0, PendValid}, 32'h0);
        adv(); chk("after_release", PC, 32'h0000_3604);

        cyc(1'b0, 1'b0, 1'b1, 32'h0000_3500, 1'b0, 1'b0, 32'h0);
        cyc(1'b0, 1'b0, 1'b0, 32'h0, 1'b1, 1'b0, 32'h0);
        chk("exc_stall_pc", PC, 32'h0000_4180);
        chk("exc_stall_pend", {31'b0, PendValid}, 32'h0);
        cyc(1'b0, 1'b1, 1'b0, 32'h0, 1'b1, 1'b1, 32'h0000_3020);
        chk("exc_over_eret", PC, 32'h0000_4180);
        cyc(1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b1, 32'h0000_3020);
        chk("eret", PC, 32'h0000_3020);

        cyc(1'b0, 1'b1, 1'b1, 32'hFFFF_FFFC, 1'b0, 1'b0, 32'h0);
        chk("pre_wrap", PC, 32'hFFFF_FFFC);
        adv(); chk("wrap", PC, 32'h0000_0000);

        cyc(1'b0, 1'b0, 1'b1, 32'h0000_3500, 1'b0, 1'b0, 32'h0);
        cyc(1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
        chk("rst_pend_pc", PC, 32'h0000_3000);
        chk("rst_pend_pv", {31'b0, PendValid}, 32'h0);
        adv(); chk("rst_pend_seq", PC, 32'h0000_3004);

        cyc(1'b0, 1'b1, 1'b1, 32'h0000_3002, 1'b0, 1'b0, 32'h0);
`ifdef PC_ADDR_CHECK_EN
        chk("adel_unaligned", {31'b0, AdEL}, 32'h1);
`else
        chk("adel_unaligned", {31'b0, AdEL}, 32'h0);
`endif
        cyc(1'b0, 1'b1, 1'b1, 32'h0000_7000, 1'b0, 1'b0, 32'h0);
`ifdef PC_ADDR_CHECK_EN
        chk("adel_high", {31'b0, AdEL}, 32'h1);
`else
        chk("adel_high", {31'b0, AdEL}, 32'h0);
`endif
        cyc(1'b0, 1'b1, 1'b1, 32'h0000_3FFC, 1'b0, 1'b0, 32'h0);
        chk("adel_ok", {31'b0, AdEL}, 32'h0);

        for (int i = 0; i < 600; i++) begin
            bit          r_rst, r_en, r_rd, r_ex, r_er;
            logic [31:0] r_tg, r_ep;
            r_rst = ($urandom_range(0, 49) == 0);
            r_en  = ($urandom_range(0, 3) != 0);
            r_rd  = ($urandom_range(0, 3) == 0);
            r_ex  = ($urandom_range(0, 19) == 0);
            r_er  = ($urandom_range(0, 19) == 0);
            r_tg  = ($urandom_range(0, 3) == 0) ? $urandom
                                                : 32'h0000_2FF0 + 32'($urandom_range(0, 16420));
            r_ep  = ($urandom_range(0, 1) == 0) ? $urandom
                                                : 32'h0000_3000 + 32'($urandom_range(0, 4095) * 4);
            cyc(r_rst, r_en, r_rd, r_tg, r_ex, r_er, r_ep);
        end

        @(negedge Clk);
        #2;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
